// File: rtl/dma_burst_engine_if.sv
// AXI4 master-side bundle used by dma_burst_engine: AW, W, B, AR and R channels.
// The master modport is the DMA engine side and the slave modport is the memory side.
interface dma_burst_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     M_AWID;
  logic [ADDR_W-1:0]   M_AWAddr;
  logic [7:0]          M_AWLen;
  logic [2:0]          M_AWSize;
  logic [1:0]          M_AWBurst;
  logic                M_AWValid;
  logic                M_AWReady;
  logic [DATA_W-1:0]   M_WData;
  logic [DATA_W/8-1:0] M_WStrb;
  logic                M_WLast;
  logic                M_WValid;
  logic                M_WReady;
  logic [ID_W-1:0]     M_BID;
  logic [1:0]          M_BResp;
  logic                M_BValid;
  logic                M_BReady;
  logic [ID_W-1:0]     M_ARID;
  logic [ADDR_W-1:0]   M_ARAddr;
  logic [7:0]          M_ARLen;
  logic [2:0]          M_ARSize;
  logic [1:0]          M_ARBurst;
  logic                M_ARValid;
  logic                M_ARReady;
  logic [ID_W-1:0]     M_RID;
  logic [DATA_W-1:0]   M_RData;
  logic [1:0]          M_RResp;
  logic                M_RLast;
  logic                M_RValid;
  logic                M_RReady;

  modport master (
    output M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid,
    input  M_AWReady,
    output M_WData, M_WStrb, M_WLast, M_WValid,
    input  M_WReady,
    input  M_BID, M_BResp, M_BValid,
    output M_BReady,
    output M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    input  M_ARReady,
    input  M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    output M_RReady
  );

  modport slave (
    input  M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid,
    output M_AWReady,
    input  M_WData, M_WStrb, M_WLast, M_WValid,
    output M_WReady,
    output M_BID, M_BResp, M_BValid,
    input  M_BReady,
    input  M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    output M_ARReady,
    output M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    input  M_RReady
  );
endinterface

// File: rtl/dma_burst_engine.sv
// AXI4 memory-to-memory DMA: splits a command into INCR bursts, each read into a buffer then written out.
// Define DMA_ERR_ABORT_EN to make SLVERR/DECERR responses set err and end the command early.
//
// state  | meaning
// IDLE   | waiting for cmd_start
// RADDR  | compute burst size, present AR until accepted
// RDATA  | collect R beats into the buffer until RLast
// WADDR  | present AW until accepted
// WDATA  | stream buffer out on W, WLast on final beat
// WRESP  | wait for B, advance addresses and remaining count
// DONE   | one-cycle done pulse
module dma_burst_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MST_ID    = 0,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  dma_burst_engine_if.master m_axi
);
  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int CW    = (LEN_W > 13) ? LEN_W : 13;

  typedef enum logic [2:0] {
    S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src, r_dst;
  logic [LEN_W-1:0]    r_rem;
  logic [8:0]          r_beats, r_idx;
  logic                r_busy, r_done, r_err;
  logic                r_arvalid, r_rready, r_awvalid, r_wvalid, r_wlast, r_bready;
  logic [ADDR_W-1:0]   r_araddr, r_awaddr;
  logic [7:0]          r_arlen, r_awlen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_buf [MAX_BURST];

  logic [CW-1:0]       w_src_room, w_dst_room, w_rem, w_min_a, w_min_b, w_min;
  logic [8:0]          w_nidx;
  logic                w_rbeat, w_rresp_err, w_bresp_err;

  // Burst length is the smallest of remaining words, buffer depth and the room left in both 4KB pages.
  assign w_src_room = CW'((13'h1000 - {1'b0, r_src[11:0]}) >> SIZE);
  assign w_dst_room = CW'((13'h1000 - {1'b0, r_dst[11:0]}) >> SIZE);
  assign w_rem      = CW'(r_rem);
  assign w_min_a    = (w_rem < CW'(MAX_BURST)) ? w_rem : CW'(MAX_BURST);
  assign w_min_b    = (w_min_a < w_src_room) ? w_min_a : w_src_room;
  assign w_min      = (w_min_b < w_dst_room) ? w_min_b : w_dst_room;

  assign w_nidx  = r_idx + 9'd1;
  assign w_rbeat = (r_state == S_RDATA) && m_axi.M_RValid && r_rready;

`ifdef DMA_ERR_ABORT_EN
  assign w_rresp_err = w_rbeat & m_axi.M_RResp[1];
  assign w_bresp_err = m_axi.M_BResp[1];
`else
  assign w_rresp_err = 1'b0;
  assign w_bresp_err = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (w_rbeat && (r_idx < r_beats)) r_buf[r_idx[IDX_W-1:0]] <= m_axi.M_RData;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_beats   <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (cmd_start && !r_busy) begin
            r_src   <= cmd_src;
            r_dst   <= cmd_dst;
            r_rem   <= cmd_len;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= (cmd_len == '0) ? S_DONE : S_RADDR;
          end else begin
            r_busy <= 1'b0;
          end
        end
        // First cycle loads the AR fields, then they are held until ARReady.
        S_RADDR: begin
          if (!r_arvalid) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_src;
            r_arlen   <= 8'(w_min - CW'(1));
            r_beats   <= 9'(w_min);
          end else if (m_axi.M_ARReady) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_idx     <= '0;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (w_rbeat) begin
            if (r_idx < r_beats) r_idx <= w_nidx;
            r_err <= r_err | w_rresp_err;
            if (m_axi.M_RLast) begin
              r_rready <= 1'b0;
              if (r_err | w_rresp_err) begin
                r_state <= S_DONE;
              end else begin
                r_awvalid <= 1'b1;
                r_awaddr  <= r_dst;
                r_awlen   <= 8'(r_beats - 9'd1);
                r_state   <= S_WADDR;
              end
            end
          end
        end
        S_WADDR: begin
          if (m_axi.M_AWReady) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wdata   <= r_buf[0];
            r_wlast   <= (r_beats == 9'd1);
            r_idx     <= '0;
            r_state   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (m_axi.M_WReady) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_WRESP;
            end else begin
              r_idx   <= w_nidx;
              r_wdata <= r_buf[w_nidx[IDX_W-1:0]];
              r_wlast <= (w_nidx == r_beats - 9'd1);
            end
          end
        end
        S_WRESP: begin
          if (m_axi.M_BValid && r_bready) begin
            r_bready <= 1'b0;
            r_rem    <= r_rem - LEN_W'(r_beats);
            r_src    <= r_src + (ADDR_W'(r_beats) << SIZE);
            r_dst    <= r_dst + (ADDR_W'(r_beats) << SIZE);
            r_err    <= r_err | w_bresp_err;
            r_state  <= ((r_rem == LEN_W'(r_beats)) || w_bresp_err) ? S_DONE : S_RADDR;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

  assign m_axi.M_ARID    = ID_W'(MST_ID);
  assign m_axi.M_ARAddr  = r_araddr;
  assign m_axi.M_ARLen   = r_arlen;
  assign m_axi.M_ARSize  = 3'(SIZE);
  assign m_axi.M_ARBurst = 2'b01;
  assign m_axi.M_ARValid = r_arvalid;
  assign m_axi.M_RReady  = r_rready;
  assign m_axi.M_AWID    = ID_W'(MST_ID);
  assign m_axi.M_AWAddr  = r_awaddr;
  assign m_axi.M_AWLen   = r_awlen;
  assign m_axi.M_AWSize  = 3'(SIZE);
  assign m_axi.M_AWBurst = 2'b01;
  assign m_axi.M_AWValid = r_awvalid;
  assign m_axi.M_WData   = r_wdata;
  assign m_axi.M_WStrb   = '1;
  assign m_axi.M_WLast   = r_wlast;
  assign m_axi.M_WValid  = r_wvalid;
  assign m_axi.M_BReady  = r_bready;
endmodule

// File: tb/tb_dma_burst_engine.sv
// Bench for dma_burst_engine: AXI slave memory model with optional random stalls,
// expected AR/AW bursts queued per command and checked as the DUT issues them.
module tb_dma_burst_engine;
  localparam int MST_ID = 3;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_src = '0;
  logic [31:0] cmd_dst = '0;
  logic [15:0] cmd_len = '0;
  logic        busy, done, err;

  dma_burst_engine_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  dma_burst_engine #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .MST_ID(MST_ID), .MAX_BURST(16), .LEN_W(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cmd_start(cmd_start), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .busy(busy), .done(done), .err(err),
    .m_axi(axi)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mem  [4096];
  logic [31:0] gold [4096];
  burst_t exp_ar[$], exp_aw[$], rd_jobs[$], wr_jobs[$];
  int  b_pend = 0, b_done = 0;
  bit  stall_en = 1'b0;
  int  err_beat = -1;
  int  valid_cycles = 0, aw_cycles = 0, done_cycles = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int stall();
    return stall_en ? int'($urandom_range(5, 0)) : 0;
  endfunction

  task automatic push_pair(input logic [31:0] ra, input logic [31:0] wa, input logic [7:0] len);
    burst_t b;
    b.addr = ra; b.len = len; exp_ar.push_back(b);
    b.addr = wa; exp_aw.push_back(b);
  endtask

  initial begin : monitor
    forever begin
      @(negedge ACLK);
      if (ARESETn) begin
        if (axi.M_ARValid || axi.M_AWValid || axi.M_WValid) valid_cycles++;
        if (axi.M_AWValid) aw_cycles++;
        if (done) done_cycles++;
      end
    end
  end

  initial begin : ar_slave
    burst_t b, e;
    int k;
    axi.M_ARReady = 1'b0;
    forever begin
      @(negedge ACLK);
      axi.M_ARReady = 1'b0;
      if (ARESETn && axi.M_ARValid) begin
        b.addr = axi.M_ARAddr; b.len = axi.M_ARLen;
        k = stall();
        repeat (k) begin
          @(negedge ACLK);
          check("ar_hold_valid", axi.M_ARValid, 1'b1);
          check("ar_hold_addr", axi.M_ARAddr, b.addr);
          check("ar_hold_len", axi.M_ARLen, b.len);
        end
        axi.M_ARReady = 1'b1;
        check("ar_id", axi.M_ARID, 4'(MST_ID));
        check("ar_size", axi.M_ARSize, 3'd2);
        check("ar_burst", axi.M_ARBurst, 2'b01);
        if (exp_ar.size() == 0) check("ar_unexpected", exp_ar.size(), 1);
        else begin
          e = exp_ar.pop_front();
          check("ar_addr", b.addr, e.addr);
          check("ar_len", b.len, e.len);
        end
        rd_jobs.push_back(b);
      end
    end
  end

  initial begin : r_slave
    burst_t j;
    int k, t;
    axi.M_RValid = 1'b0; axi.M_RLast = 1'b0; axi.M_RResp = 2'b00;
    axi.M_RData = '0; axi.M_RID = 4'(MST_ID);
    forever begin
      @(negedge ACLK);
      if (rd_jobs.size() > 0) begin
        j = rd_jobs.pop_front();
        for (int i = 0; i <= int'(j.len); i++) begin
          k = stall();
          repeat (k) @(negedge ACLK);
          axi.M_RValid = 1'b1;
          axi.M_RData  = mem[int'(j.addr[13:2]) + i];
          axi.M_RResp  = (i == err_beat) ? 2'b10 : 2'b00;
          axi.M_RLast  = (i == int'(j.len));
          t = 0;
          while (!axi.M_RReady && t < 200) begin @(negedge ACLK); t++; end
          check("r_ready_timeout", t < 200, 1'b1);
          @(negedge ACLK);
          axi.M_RValid = 1'b0; axi.M_RLast = 1'b0; axi.M_RResp = 2'b00;
        end
        err_beat = -1;
      end
    end
  end

  initial begin : aw_slave
    burst_t b, e;
    int k;
    axi.M_AWReady = 1'b0;
    forever begin
      @(negedge ACLK);
      axi.M_AWReady = 1'b0;
      if (ARESETn && axi.M_AWValid) begin
        b.addr = axi.M_AWAddr; b.len = axi.M_AWLen;
        k = stall();
        repeat (k) begin
          @(negedge ACLK);
          check("aw_hold_valid", axi.M_AWValid, 1'b1);
          check("aw_hold_addr", axi.M_AWAddr, b.addr);
          check("aw_hold_len", axi.M_AWLen, b.len);
        end
        axi.M_AWReady = 1'b1;
        check("aw_id", axi.M_AWID, 4'(MST_ID));
        check("aw_size", axi.M_AWSize, 3'd2);
        check("aw_burst", axi.M_AWBurst, 2'b01);
        if (exp_aw.size() == 0) check("aw_unexpected", exp_aw.size(), 1);
        else begin
          e = exp_aw.pop_front();
          check("aw_addr", b.addr, e.addr);
          check("aw_len", b.len, e.len);
        end
        wr_jobs.push_back(b);
      end
    end
  end

  initial begin : w_slave
    burst_t j;
    int k, t;
    logic [31:0] d;
    logic l;
    axi.M_WReady = 1'b0;
    forever begin
      @(negedge ACLK);
      if (wr_jobs.size() > 0) begin
        j = wr_jobs.pop_front();
        for (int i = 0; i <= int'(j.len); i++) begin
          t = 0;
          while (!axi.M_WValid && t < 200) begin @(negedge ACLK); t++; end
          check("w_valid_timeout", t < 200, 1'b1);
          d = axi.M_WData; l = axi.M_WLast;
          k = stall();
          repeat (k) begin
            @(negedge ACLK);
            check("w_hold_valid", axi.M_WValid, 1'b1);
            check("w_hold_data", axi.M_WData, d);
            check("w_hold_last", axi.M_WLast, l);
          end
          axi.M_WReady = 1'b1;
          check("w_last", axi.M_WLast, (i == int'(j.len)));
          check("w_strb", axi.M_WStrb, 4'hF);
          mem[int'(j.addr[13:2]) + i] = axi.M_WData;
          @(negedge ACLK);
          axi.M_WReady = 1'b0;
        end
        b_pend++;
      end
    end
  end

  initial begin : b_slave
    int k, t;
    axi.M_BValid = 1'b0; axi.M_BResp = 2'b00; axi.M_BID = 4'(MST_ID);
    forever begin
      @(negedge ACLK);
      if (b_pend > 0) begin
        b_pend--;
        k = stall();
        repeat (k) @(negedge ACLK);
        axi.M_BValid = 1'b1;
        t = 0;
        while (!axi.M_BReady && t < 200) begin @(negedge ACLK); t++; end
        check("b_ready_timeout", t < 200, 1'b1);
        @(negedge ACLK);
        axi.M_BValid = 1'b0;
        b_done++;
      end
    end
  end

  task automatic run_cmd(input string tag, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] len, input int nb, input logic exp_err,
                         input bit chk_data, input bit poke);
    int t, d0, b0;
    for (int i = 0; i < 4096; i++) gold[i] = mem[i];
    d0 = done_cycles; b0 = b_done;
    @(negedge ACLK);
    cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_start = 1'b1;
    @(negedge ACLK);
    cmd_start = 1'b0;
    check({tag, "_busy_set"}, busy, 1'b1);
    if (poke) begin
      repeat (3) @(negedge ACLK);
      cmd_src = 32'h900; cmd_len = 16'd3; cmd_start = 1'b1;
      @(negedge ACLK);
      cmd_start = 1'b0;
    end
    t = 0;
    while (done !== 1'b1 && t < 3000) begin @(negedge ACLK); t++; end
    check({tag, "_done_timeout"}, t < 3000, 1'b1);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_bursts"}, b_done - b0, nb);
    @(negedge ACLK);
    check({tag, "_done_pulses"}, done_cycles - d0, 1);
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_ar_left"}, exp_ar.size(), 0);
    check({tag, "_aw_left"}, exp_aw.size(), 0);
    if (chk_data)
      for (int i = 0; i < int'(len); i++)
        check({tag, "_data"}, mem[int'(dst[13:2]) + i], gold[int'(src[13:2]) + i]);
  endtask

  initial begin : main
    int v0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    repeat (3) @(negedge ACLK);
    check("rst_arvalid", axi.M_ARValid, 1'b0);
    check("rst_awvalid", axi.M_AWValid, 1'b0);
    check("rst_wvalid", axi.M_WValid, 1'b0);
    check("rst_rready", axi.M_RReady, 1'b0);
    check("rst_bready", axi.M_BReady, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_araddr", axi.M_ARAddr, 32'h0);
    check("rst_awaddr", axi.M_AWAddr, 32'h0);
    check("rst_wdata", axi.M_WData, 32'h0);
    check("rst_arlen", axi.M_ARLen, 8'h0);
    check("rst_awlen", axi.M_AWLen, 8'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    push_pair(32'h100, 32'h2000, 8'd4);
    run_cmd("len5", 32'h100, 32'h2000, 16'd5, 1, 1'b0, 1'b1, 1'b0);

    push_pair(32'h400, 32'h2400, 8'd15);
    push_pair(32'h440, 32'h2440, 8'd15);
    push_pair(32'h480, 32'h2480, 8'd7);
    run_cmd("len40", 32'h400, 32'h2400, 16'd40, 3, 1'b0, 1'b1, 1'b0);

    push_pair(32'h0FF8, 32'h3000, 8'd1);
    push_pair(32'h1000, 32'h3008, 8'd5);
    run_cmd("src4k", 32'h0FF8, 32'h3000, 16'd8, 2, 1'b0, 1'b1, 1'b0);

    push_pair(32'h500, 32'h1FF0, 8'd3);
    push_pair(32'h510, 32'h2000, 8'd1);
    run_cmd("dst4k", 32'h500, 32'h1FF0, 16'd6, 2, 1'b0, 1'b1, 1'b0);

    stall_en = 1'b1;
    push_pair(32'h1800, 32'h3800, 8'd15);
    push_pair(32'h1840, 32'h3840, 8'd3);
    run_cmd("stall20", 32'h1800, 32'h3800, 16'd20, 2, 1'b0, 1'b1, 1'b0);
    push_pair(32'h0FF0, 32'h3400, 8'd3);
    push_pair(32'h1000, 32'h3410, 8'd4);
    run_cmd("stall4k", 32'h0FF0, 32'h3400, 16'd9, 2, 1'b0, 1'b1, 1'b0);
    stall_en = 1'b0;

    push_pair(32'h700, 32'h2800, 8'd4);
    run_cmd("busy_start", 32'h700, 32'h2800, 16'd5, 1, 1'b0, 1'b1, 1'b1);
    v0 = valid_cycles;
    repeat (6) @(negedge ACLK);
    check("busy_start_idle", busy, 1'b0);
    check("busy_start_quiet", valid_cycles - v0, 0);

    err_beat = 1;
    v0 = aw_cycles;
`ifdef DMA_ERR_ABORT_EN
    begin
      burst_t b;
      b.addr = 32'h600; b.len = 8'd3; exp_ar.push_back(b);
    end
    run_cmd("rerr", 32'h600, 32'h2600, 16'd4, 0, 1'b1, 1'b0, 1'b0);
    check("rerr_no_aw", aw_cycles - v0, 0);
`else
    push_pair(32'h600, 32'h2600, 8'd3);
    run_cmd("rerr", 32'h600, 32'h2600, 16'd4, 1, 1'b0, 1'b1, 1'b0);
    check("rerr_aw_seen", aw_cycles - v0 > 0, 1'b1);
`endif

    v0 = valid_cycles;
    @(negedge ACLK);
    cmd_src = 32'h100; cmd_dst = 32'h2000; cmd_len = 16'd0; cmd_start = 1'b1;
    @(negedge ACLK);
    cmd_start = 1'b0;
    check("len0_busy", busy, 1'b1);
    check("len0_done_early", done, 1'b0);
    check("len0_err_clear", err, 1'b0);
    @(negedge ACLK);
    check("len0_done", done, 1'b1);
    @(negedge ACLK);
    check("len0_done_low", done, 1'b0);
    check("len0_busy_low", busy, 1'b0);
    repeat (4) @(negedge ACLK);
    check("len0_no_valid", valid_cycles - v0, 0);

    push_pair(32'h400, 32'h2400, 8'd15);
    push_pair(32'h440, 32'h2440, 8'd15);
    push_pair(32'h480, 32'h2480, 8'd7);
    @(negedge ACLK);
    cmd_src = 32'h400; cmd_dst = 32'h2400; cmd_len = 16'd40; cmd_start = 1'b1;
    @(negedge ACLK);
    cmd_start = 1'b0;
    repeat (25) @(negedge ACLK);
    check("mid_rst_busy_before", busy, 1'b1);
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_arvalid", axi.M_ARValid, 1'b0);
    check("mid_rst_awvalid", axi.M_AWValid, 1'b0);
    check("mid_rst_wvalid", axi.M_WValid, 1'b0);
    check("mid_rst_rready", axi.M_RReady, 1'b0);
    check("mid_rst_bready", axi.M_BReady, 1'b0);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    check("mid_rst_discarded", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
